smg_decode_capture: RTL and testbench

SMG_DECODE_CAPTURE -- requirements
Module: smg_decode_capture

---
 rtl/smg_decode_capture.sv | 141 ++++++++++++++
 tb/tb_smg_decode_capture.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/smg_decode_capture.sv
// rtl/smg_decode_capture.sv - seven-segment digit capture/decode with valid/ready output
// Optional decimal-point decode: define SMG_DP_DECODE_EN.
module smg_decode_capture #(
    parameter int STABLE_CYCLES = 1000
) (
    input  logic       clk_50M,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    input  logic       led_bit_in,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] hex_out,
    output logic       dp_out,
    output logic       pat_err,
    output logic       overrun,
    output logic [7:0] chg_count
);

`ifdef SMG_DP_DECODE_EN
    localparam logic [7:0] SEG_MASK = 8'hFF;
    localparam logic       DP_EN    = 1'b1;
`else
    localparam logic [7:0] SEG_MASK = 8'h7F;
    localparam logic       DP_EN    = 1'b0;
`endif
    localparam logic [15:0] CNT_MAX  = 16'(STABLE_CYCLES);
    localparam logic [15:0] CNT_LAST = 16'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, TRACK, LOCKED} state_t;

    state_t      state;
    logic [7:0]  seg_s1, seg_s2, seg_prev, last_pat, seg_m;
    logic        led_s1, led_s2, last_ok;
    logic [15:0] cnt;
    logic        same, stable_evt, decode_evt, load;
    logic [4:0]  dec;

    // {pat_err, hex}; unmatched glyphs report hex 0
    function automatic logic [4:0] decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = 5'h00;
            7'b1111001: r = 5'h01;
            7'b0100100: r = 5'h02;
            7'b0110000: r = 5'h03;
            7'b0011001: r = 5'h04;
            7'b0010010: r = 5'h05;
            7'b0000010: r = 5'h06;
            7'b1111000: r = 5'h07;
            7'b0000000: r = 5'h08;
            7'b0010000: r = 5'h09;
            7'b0001000: r = 5'h0A;
            7'b0000011: r = 5'h0B;
            7'b1000110: r = 5'h0C;
            7'b0100001: r = 5'h0D;
            7'b0000110: r = 5'h0E;
            7'b0001110: r = 5'h0F;
            default:    r = 5'h10;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1 <= 8'hFF;
            seg_s2 <= 8'hFF;
            led_s1 <= 1'b1;
            led_s2 <= 1'b1;
        end else begin
            seg_s1 <= seg_in;
            seg_s2 <= seg_s1;
            led_s1 <= led_bit_in;
            led_s2 <= led_s1;
        end
    end

    always_comb begin
        seg_m      = seg_s2 & SEG_MASK;
        same       = (seg_m == seg_prev);
        stable_evt = (state == TRACK) && !led_s2 && same && (cnt == CNT_LAST);
        decode_evt = stable_evt && (!last_ok || (seg_m != last_pat));
        load       = decode_evt && (!valid || ready);
        dec        = decode(seg_m[6:0]);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            seg_prev  <= SEG_MASK;
            last_pat  <= '0;
            last_ok   <= 1'b0;
            valid     <= 1'b0;
            hex_out   <= '0;
            dp_out    <= 1'b0;
            pat_err   <= 1'b0;
            overrun   <= 1'b0;
            chg_count <= '0;
        end else begin
            seg_prev <= seg_m;
            if (led_s2) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= TRACK;
                        cnt   <= '0;
                    end
                    TRACK, LOCKED: begin
                        if (!same)
                            cnt <= '0;
                        else if (cnt != CNT_MAX)
                            cnt <= cnt + 16'd1;
                        if (stable_evt)
                            state <= LOCKED;
                        else if ((state == LOCKED) && !same)
                            state <= TRACK;
                    end
                    default: state <= IDLE;
                endcase
            end

            // a pending unaccepted output is never overwritten; the newer event is lost
            if (load) begin
                valid     <= 1'b1;
                hex_out   <= dec[3:0];
                pat_err   <= dec[4];
                dp_out    <= DP_EN & ~seg_m[7];
                chg_count <= chg_count + 8'd1;
                last_pat  <= seg_m;
                last_ok   <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (decode_evt && !load)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_smg_decode_capture.sv
// tb/tb_smg_decode_capture.sv - self-checking bench for smg_decode_capture (STABLE_CYCLES=4)
module tb_smg_decode_capture;

    localparam int         S    = 4;
    localparam int         N    = S + 4;
    localparam logic [8:0] SENT = 9'h100;
`ifdef SMG_DP_DECODE_EN
    localparam logic [7:0] MASK  = 8'hFF;
    localparam logic       DP_EN = 1'b1;
`else
    localparam logic [7:0] MASK  = 8'h7F;
    localparam logic       DP_EN = 1'b0;
`endif

    logic       clk_50M = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] seg_in = 8'hFF;
    logic       led_bit_in = 1'b1;
    logic       ready = 1'b0;
    logic       valid, dp_out, pat_err, overrun;
    logic [3:0] hex_out;
    logic [7:0] chg_count;
    logic [15:0] dut_vec;

    smg_decode_capture #(.STABLE_CYCLES(S)) dut (
        .clk_50M(clk_50M), .rst_n(rst_n), .seg_in(seg_in), .led_bit_in(led_bit_in),
        .ready(ready), .valid(valid), .hex_out(hex_out), .dp_out(dp_out),
        .pat_err(pat_err), .overrun(overrun), .chg_count(chg_count)
    );

    always #10 clk_50M = ~clk_50M;
    assign dut_vec = {valid, hex_out, dp_out, pat_err, overrun, chg_count};

    int checks = 0;
    int errors = 0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference: the sample seen at each edge (sentinel while digit select is high),
    // a pattern becomes stable once S+1 identical samples have been seen two edges ago.
    logic [8:0] hist [$];
    logic       m_valid, m_dp, m_err, m_ovr, m_last_ok;
    logic [3:0] m_hex;
    logic [7:0] m_cnt, m_last;

    function automatic logic [15:0] exp_vec();
        return {m_valid, m_hex, m_dp, m_err, m_ovr, m_cnt};
    endfunction

    task automatic model_reset();
        {m_valid, m_dp, m_err, m_ovr, m_last_ok} = '0;
        m_hex = '0; m_cnt = '0; m_last = '0;
        hist.delete();
        for (int i = 0; i < N; i++) hist.push_back(SENT);
    endtask

    task automatic model_edge();
        logic [8:0] x;
        logic [7:0] p;
        logic       evt;
        int         code;
        x = led_bit_in ? SENT : {1'b0, seg_in & MASK};
        hist.push_back(x);
        void'(hist.pop_front());
        x = hist[S+1];
        p = x[7:0];
        evt = (x != SENT) && (hist[0] != x);
        for (int k = 1; k <= S; k++) if (hist[k] != x) evt = 1'b0;
        if (evt && m_last_ok && (p == m_last)) evt = 1'b0;
        if (evt && m_valid && !ready) begin
            m_ovr = 1'b1;
        end else if (evt) begin
            code = 16;
            for (int g = 0; g < 16; g++) if (glyph[g] == p[6:0]) code = g;
            m_valid = 1'b1;
            m_err = (code == 16);
            m_hex = (code == 16) ? 4'h0 : code[3:0];
            m_dp = DP_EN & ~p[7];
            m_cnt = m_cnt + 8'd1;
            m_last = p;
            m_last_ok = 1'b1;
        end else if (m_valid && ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk_50M);
        model_edge();
        @(negedge clk_50M);
    endtask

    task automatic test_reset();
        logic [15:0] exp;
        seg_in = 8'hC0; led_bit_in = 1'b0; ready = 1'b1; rst_n = 1'b0;
        repeat (2) @(negedge clk_50M);
        model_reset();
        checks++;
        if (dut_vec !== 16'h0) begin
            errors++; $display("FAIL reset_outputs got=%h want=0000", dut_vec);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = (e == 7) ? 16'h8001 : (e == 8) ? 16'h0001 : 16'h0000;
            checks++;
            if (dut_vec !== exp) begin
                errors++; $display("FAIL first_event edge%0d got=%h want=%h", e, dut_vec, exp);
            end
        end
    endtask

    task automatic test_sequence();
        logic [7:0] pats [2] = '{8'hF9, 8'hA4};
        int seen = 0;
        ready = 1'b1;
        foreach (pats[p]) begin
            seg_in = pats[p];
            for (int i = 0; i < 10; i++) begin
                tick();
                if (valid) seen = seen * 16 + int'(hex_out);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL sequence got=%h want=%h", dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (seen != 'h12 || chg_count !== 8'd3) begin
            errors++; $display("FAIL sequence_events got=%h/%0d want=12/3", seen, chg_count);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] pats [2] = '{8'hF9, 8'h92};
        ready = 1'b0;
        foreach (pats[p]) begin
            seg_in = pats[p];
            for (int i = 0; i < 10; i++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL overrun got=%h want=%h", dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (dut_vec !== 16'h8904) begin
            errors++; $display("FAIL overrun_hold got=%h want=8904", dut_vec);
        end
        ready = 1'b1;
        tick();
        checks++;
        if (dut_vec !== 16'h0904) begin
            errors++; $display("FAIL overrun_handshake got=%h want=0904", dut_vec);
        end
    endtask

    task automatic test_glitch();
        logic [7:0] pats [3] = '{8'hC0, 8'hF9, 8'hC0};
        int holds [3] = '{10, 2, 10};
        ready = 1'b1;
        foreach (pats[p]) begin
            seg_in = pats[p];
            for (int i = 0; i < holds[p]; i++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec() || (p > 0 && valid !== 1'b0)) begin
                    errors++; $display("FAIL glitch got=%h want=%h", dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (dut_vec !== 16'h0105) begin
            errors++; $display("FAIL glitch_final got=%h want=0105", dut_vec);
        end
    endtask

    task automatic test_dp();
        logic saw = 1'b0;
        logic [15:0] want = DP_EN ? 16'h0506 : 16'h0105;
        ready = 1'b1; seg_in = 8'h40;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid && dp_out && hex_out == 4'h0) saw = 1'b1;
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL dp got=%h want=%h", dut_vec, exp_vec());
            end
        end
        checks++;
        if (saw !== DP_EN || dut_vec !== want) begin
            errors++; $display("FAIL dp_event got=%b/%h want=%b/%h", saw, dut_vec, DP_EN, want);
        end
    endtask

    task automatic test_idle_retain();
        ready = 1'b0; seg_in = 8'hB0;
        for (int i = 0; i < 22; i++) begin
            led_bit_in = (i >= 10 && i < 16);
            seg_in = led_bit_in ? 8'($urandom) : 8'hB0;
            tick();
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL idle got=%h want=%h", dut_vec, exp_vec());
            end
        end
        checks++;
        if ({valid, hex_out, pat_err} !== 6'b1_0011_0) begin
            errors++; $display("FAIL idle_retain got=%b%h%b want=130", valid, hex_out, pat_err);
        end
        led_bit_in = 1'b0; ready = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        ready = 1'b1;
        for (int n = 0; n < 270; n++) begin
            seg_in = n[0] ? 8'hF9 : 8'h99;
            for (int i = 0; i < S + 2; i++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL wrap got=%h want=%h", dut_vec, exp_vec());
                end
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] p = 8'hC0;
        int hold;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: p = 8'($urandom);
                1: p = p ^ 8'h80;
                default: p = {1'($urandom), glyph[$urandom_range(0, 15)]};
            endcase
            hold = $urandom_range(1, 2 * S + 2);
            led_bit_in = ($urandom_range(0, 9) == 0);
            seg_in = p;
            for (int i = 0; i < hold; i++) begin
                ready = ($urandom_range(0, 3) != 0);
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL random seg=%h got=%h want=%h", p, dut_vec, exp_vec());
                end
            end
        end
        led_bit_in = 1'b0;
    endtask

    task automatic test_pat_err_reset();
        logic [7:0] pats [3] = '{8'hA4, 8'hC0, 8'hFF};
        foreach (pats[p]) begin
            seg_in = pats[p]; ready = (p < 2);
            for (int i = 0; i < 10; i++) begin
                tick();
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL pat_err got=%h want=%h", dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if ({valid, hex_out, pat_err} !== 6'b1_0000_1) begin
            errors++; $display("FAIL pat_err_out got=%b%h%b want=101", valid, hex_out, pat_err);
        end
        @(posedge clk_50M);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 16'h0) begin
            errors++; $display("FAIL async_reset got=%h want=0000", dut_vec);
        end
        repeat (2) @(negedge clk_50M);
        model_reset();
        ready = 1'b1; rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (dut_vec !== exp_vec() || (e == 7 && dut_vec !== 16'h8201)) begin
                errors++; $display("FAIL post_reset edge%0d got=%h want=%h", e, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_overrun();
        test_glitch();
        test_dp();
        test_idle_retain();
        test_wrap();
        test_random();
        test_pat_err_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
